// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit-id encodings, router port indices and the
// output-arbiter state type.
package noc_pkg;

  localparam logic [2:0] HEADER  = 3'b001;
  localparam logic [2:0] PAYLOAD = 3'b010;
  localparam logic [2:0] TAIL    = 3'b100;

  localparam int unsigned PORT_N = 0;
  localparam int unsigned PORT_E = 1;
  localparam int unsigned PORT_W = 2;
  localparam int unsigned PORT_S = 3;
  localparam int unsigned PORT_L = 4;

  localparam int unsigned SEL_W = 3;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_t;

endpackage

// File: rtl/lbdr_output_arbiter_if.sv
// Request/flit bundle between the five input FIFOs and one output-port arbiter.
interface lbdr_output_arbiter_if
  import noc_pkg::*;
#(
  parameter int unsigned N_REQ     = 5,
  parameter int unsigned FLIT_ID_W = 3
);
  logic [N_REQ-1:0]                req;
  logic [N_REQ-1:0]                valid;
  logic [N_REQ-1:0][FLIT_ID_W-1:0] flit_id;
  logic                            out_ready;
  logic [N_REQ-1:0]                grant;
  logic [SEL_W-1:0]                sel;
  logic [N_REQ-1:0]                read_en;
  logic                            out_valid;
  logic                            busy;
  logic                            err;

  modport master (
    output req, valid, flit_id, out_ready,
    input  grant, sel, read_en, out_valid, busy, err
  );

  modport slave (
    input  req, valid, flit_id, out_ready,
    output grant, sel, read_en, out_valid, busy, err
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set elig bit searching from ptr upward, wrapping.
module rr_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned N_REQ = 5
) (
  input  logic [N_REQ-1:0] elig,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_REQ-1:0] win,
  output logic [SEL_W-1:0] win_idx,
  output logic             any
);

  always_comb begin
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      int unsigned idx;
      idx = (32'(ptr) + k) % N_REQ;
      if (!any && elig[idx]) begin
        any      = 1'b1;
        win[idx] = 1'b1;
        win_idx  = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/lbdr_output_arbiter.sv
// Per-output-port arbiter: round-robin on HEADER flits, then locks the output
// to the winning input until its TAIL flit has transferred.
module lbdr_output_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned N_REQ     = 5,
  parameter int unsigned FLIT_ID_W = 3
) (
  input logic                  clk,
  input logic                  rst,
  lbdr_output_arbiter_if.slave bus
);

  arb_state_t       state, state_nxt;
  logic [N_REQ-1:0] grant_q, grant_nxt;
  logic [SEL_W-1:0] sel_q, sel_nxt;
  logic [SEL_W-1:0] ptr_q, ptr_nxt;
  logic             err_q, err_nxt;
  logic             hdr_done_q, hdr_done_nxt;

  logic [N_REQ-1:0]     elig;
  logic [N_REQ-1:0]     win;
  logic [SEL_W-1:0]     win_idx;
  logic                 any;
  logic                 xfer;
  logic [FLIT_ID_W-1:0] head;

  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      elig[i] = bus.req[i] & bus.valid[i] & (bus.flit_id[i] == FLIT_ID_W'(HEADER));
    end
  end

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .elig    (elig),
    .ptr     (ptr_q),
    .win     (win),
    .win_idx (win_idx),
    .any     (any)
  );

  assign head = bus.flit_id[sel_q];
  // Pops are suppressed while rst is high so a reset mid-packet never consumes a flit.
  assign xfer = (state == LOCKED) & bus.valid[sel_q] & bus.out_ready & ~rst;

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant_q;
    sel_nxt      = sel_q;
    ptr_nxt      = ptr_q;
    err_nxt      = err_q;
    hdr_done_nxt = hdr_done_q;
    unique case (state)
      IDLE: begin
        if (any) begin
          state_nxt    = LOCKED;
          grant_nxt    = win;
          sel_nxt      = win_idx;
          hdr_done_nxt = 1'b0;
        end
      end
      LOCKED: begin
        if (xfer) begin
          hdr_done_nxt = 1'b1;
          // Only the first flit of a locked packet may be a HEADER.
          if (hdr_done_q && head == FLIT_ID_W'(HEADER)) err_nxt = 1'b1;
          if (head == FLIT_ID_W'(TAIL)) begin
            state_nxt = IDLE;
            grant_nxt = '0;
            ptr_nxt   = (sel_q == SEL_W'(N_REQ - 1)) ? '0 : sel_q + SEL_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant_q    <= '0;
      sel_q      <= '0;
      ptr_q      <= '0;
      err_q      <= 1'b0;
      hdr_done_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant_q    <= grant_nxt;
      sel_q      <= sel_nxt;
      ptr_q      <= ptr_nxt;
      err_q      <= err_nxt;
      hdr_done_q <= hdr_done_nxt;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.sel       = sel_q;
  assign bus.read_en   = xfer ? grant_q : '0;
  assign bus.out_valid = xfer;
  assign bus.busy      = (state == LOCKED);
  assign bus.err       = err_q;

endmodule

// File: doc/lbdr_output_arbiter.md
# lbdr_output_arbiter

One instance per router output port. It shares that output between the five input ports whose LBDR stages route a packet to it. Arbitration is round-robin among header flits. Once a packet wins, the output stays locked to that input until its TAIL flit has transferred. The block drives the output crossbar select and the pop strobes of the input FIFOs.

## Interface
Parameters:
- N_REQ, 5, number of requesters; index 0..4 = N, E, W, S, L.
- FLIT_ID_W, 3, width of flit-id field.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req  in  N_REQ  per-input route request; bit i = the LBDR port bit for this output from input i.
- valid  in  N_REQ  per-input FIFO non-empty.
- flit_id  in  N_REQ×FLIT_ID_W  flit id at the head of each input FIFO.
- out_ready  in  1  downstream can accept a flit this cycle.
- grant  out  N_REQ  registered one-hot owner; all-zero when idle.
- sel  out  3  registered binary index of the owner, driving the crossbar mux.
- read_en  out  N_REQ  pop strobe to input FIFOs; combinational.
- out_valid  out  1  flit transferred this cycle; combinational.
- busy  out  1  state == LOCKED.
- err  out  1  sticky protocol-error flag.

## Operation
- Flit-id encoding: HEADER = 3'b001, PAYLOAD = 3'b010, TAIL = 3'b100. Every packet is HEADER, then zero or more PAYLOAD flits, then TAIL, so it is at least 2 flits.
- Eligible(i) = req[i] & valid[i] & (flit_id[i] == HEADER).
- FSM states:
  - IDLE: if any input is eligible, pick the winner by round-robin starting at ptr. Register grant = onehot(winner) and sel = winner, then go to LOCKED. If none is eligible, stay in IDLE.
  - LOCKED: xfer = valid[sel] & out_ready. On xfer, read_en[sel] = 1 and out_valid = 1. Other read_en bits are always 0.
  - If xfer and flit_id[sel] == TAIL: go to IDLE, clear grant to 0 and set ptr = (sel + 1) mod N_REQ, wrapping 4 to 0.
- Round-robin: the search order is ptr, ptr+1, …, wrapping. The first eligible index wins. ptr changes only on TAIL transfer.
- The first transfer in LOCKED is the winner's HEADER. If a later transferred flit is HEADER, set err = 1. The flit is still transferred and the lock is held until a TAIL.
- valid[sel] low while LOCKED (FIFO empty mid-packet): stall, hold grant, issue no read_en.
- out_ready low: stall with the same behaviour.
- req changes while LOCKED are ignored. req is sampled only in IDLE.
- A non-owner input whose head is PAYLOAD or TAIL is never eligible.

## Timing
- Reset values: state IDLE, grant 0, sel 0, ptr 0, err 0. Hence busy 0, read_en 0, out_valid 0.
- rst dominates every other input on the same edge, including mid-packet. Any lock is dropped and no pop occurs in the reset cycle.
- Arbitration latency: input eligible in cycle k gives grant at the edge ending k. The header can transfer in cycle k+1.
- Throughput while locked: 1 flit/cycle when valid and out_ready are both high.
- After a TAIL transfer there is exactly one IDLE cycle before the next header can transfer (one bubble per packet).
- err sets on the edge after the offending transfer and clears only on rst.

## Structure
- Shared package noc_pkg holds:
  - the HEADER/PAYLOAD/TAIL localparams;
  - the port-index constants PORT_N = 0, PORT_E = 1, PORT_W = 2, PORT_S = 3, PORT_L = 4;
  - the typedef enum for the arbiter state {IDLE, LOCKED}.
- Sub-module rr_arbiter: purely combinational round-robin picker. Parameter N_REQ; inputs elig[N_REQ] and ptr. Outputs a one-hot win, a binary win_idx and any. The FSM, ptr and err registers stay in lbdr_output_arbiter.

## Test plan
- Reset mid-packet: E locked after 2 PAYLOAD flits, assert rst → next cycle grant 0, busy 0, ptr 0, no read_en during the rst cycle.
- Single request: L eligible at cycle 0 with 3-flit packet H, P, T and out_ready = 1 → grant = 5'b10000 and sel = 4 at cycle 1, read_en[4] in cycles 1-3, busy drops and ptr = 0 after cycle 3.
- Contention: N, W and S eligible simultaneously with ptr 0 → order N, W, S. After N's TAIL, ptr = 1 and W wins, not S. After W's TAIL, ptr = 3 and S wins.
- Wrap-around: ptr = 4 with L and N eligible → L wins, ptr becomes 0 after its TAIL, then N wins.
- Stalls: owner E, toggle out_ready 1, 0, 1 and drop valid[1] for 2 cycles → out_valid only when both are high, grant held throughout, flit count is preserved.
- Protocol error: owner sends H, H, T → both HEADERs transferred, err = 1 after the second, grant released after T, err still 1 until rst.
